// File: rtl/rf_wport_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package rf_wport_arb_pkg;

  localparam int unsigned AddrW   = 5;
  localparam int unsigned DataW   = 32;
  localparam int unsigned CntW    = 4;
  localparam int unsigned NumRegs = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLuWait,
    StLuForce
  } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared when the long-latency unit writes the register back.
module rf_scoreboard
  import rf_wport_arb_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               set,
  input  logic [AddrW-1:0]   set_addr,
  input  logic               clr,
  input  logic [AddrW-1:0]   clr_addr,
  input  logic [AddrW-1:0]   chk_addr1,
  input  logic [AddrW-1:0]   chk_addr2,
  input  logic [AddrW-1:0]   chk_addr3,
  output logic [NumRegs-1:0] busy,
  output logic               hazard
);

  logic [NumRegs-1:0] busy_q, busy_d;

  // Clear first so that a same-cycle set of the same bit wins; x0 never pends.
  always_comb begin
    busy_d = busy_q;
    if (clr) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set && (set_addr != '0)) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Bitmap register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  // Bit 0 is held clear, so address 0 can never report a hazard.
  assign hazard = busy_q[chk_addr1] | busy_q[chk_addr2] | busy_q[chk_addr3];

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority, a
// long-latency unit (LU) write is forced through after STARVE_MAX refusals.
// Optional pending-register scoreboard enabled by RF_ARB_SCOREBOARD_EN.
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wb_we,
  input  logic [AddrW-1:0]   wb_waddr,
  input  logic [DataW-1:0]   wb_wdata,
  output logic               wb_stall,
  input  logic               lu_valid,
  input  logic [AddrW-1:0]   lu_waddr,
  input  logic [DataW-1:0]   lu_wdata,
  output logic               lu_ready,
  output logic               rf_we,
  output logic [AddrW-1:0]   rf_waddr,
  output logic [DataW-1:0]   rf_wdata,
  input  logic               sb_set,
  input  logic [AddrW-1:0]   sb_set_addr,
  input  logic [AddrW-1:0]   chk_addr1,
  input  logic [AddrW-1:0]   chk_addr2,
  input  logic [AddrW-1:0]   chk_addr3,
  output logic               hazard,
  output logic [NumRegs-1:0] sb_busy
);

  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            forced;
  logic            lu_grant;
  logic            wb_grant;
  logic            lu_refused;

  // Grants are masked by reset so nothing reaches the register file meanwhile.
  assign forced     = (state_q == StLuForce);
  assign lu_grant   = resetn && lu_valid && (forced || !wb_we);
  assign wb_grant   = resetn && wb_we && !forced;
  assign lu_refused = lu_valid && !lu_grant;
  assign lu_ready   = lu_grant;
  assign wb_stall   = resetn && forced && wb_we;

  // Next state and starvation counter. The counter is zero whenever in IDLE,
  // so IDLE jumps straight to LU_FORCE only when STARVE_MAX is 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (lu_refused) begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = (cnt_d >= StarveMax) ? StLuForce : StLuWait;
        end else begin
          cnt_d = '0;
        end
      end
      StLuWait: begin
        if (!lu_valid || lu_grant) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d >= StarveMax) begin
            state_d = StLuForce;
          end
        end
      end
      StLuForce: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter state and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write-port mux; writes to x0 are dropped but the handshake still completes.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (lu_grant) begin
      rf_we    = (lu_waddr != '0);
      rf_waddr = lu_waddr;
      rf_wdata = lu_wdata;
    end else if (wb_grant) begin
      rf_we    = (wb_waddr != '0);
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .resetn    (resetn),
    .set       (sb_set),
    .set_addr  (sb_set_addr),
    .clr       (lu_grant),
    .clr_addr  (lu_waddr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_addr3 (chk_addr3),
    .busy      (sb_busy),
    .hazard    (hazard)
  );
`else
  assign sb_busy = '0;
  assign hazard  = 1'b0;

  logic unused_sb;
  assign unused_sb = ^{sb_set, sb_set_addr, chk_addr1, chk_addr2, chk_addr3};
`endif

endmodule

// File: doc/rf_wport_arb.md
RF_WPORT_ARB -- requirements
Module: rf_wport_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive cycles a pending long-latency write may be refused before it is forced onto the port (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, the reset, asynchronous and active-low.
REQ-004 SHALL have ports wb_we, wb_waddr, wb_wdata: input, 1/5/32, pipeline writeback request.
REQ-005 SHALL have port wb_stall, output, 1, pipeline writeback must hold its request this cycle.
REQ-006 SHALL have ports lu_valid, lu_waddr, lu_wdata: input, 1/5/32, long-latency unit (mul/div/load-miss) write request.
REQ-007 SHALL have port lu_ready, output, 1, LU write accepted this cycle.
REQ-008 SHALL have ports rf_we, rf_waddr, rf_wdata: output, 1/5/32, drive the register file write port.
REQ-009 SHALL have ports sb_set, sb_set_addr: input, 1/5, issue marks a destination as pending on the LU.
REQ-010 SHALL have ports chk_addr1, chk_addr2, chk_addr3: input, 5 each, read sources and write destination of the instruction in decode.
REQ-011 SHALL have port hazard, output, 1, any checked address is pending.
REQ-012 SHALL have port sb_busy, output, 32, pending bitmap; bit 0 always 0.

Function
REQ-013 SHALL implement FSM states IDLE, LU_WAIT, LU_FORCE.
REQ-014 In IDLE/LU_WAIT SHALL grant WB whenever wb_we=1; LU granted only when wb_we=0.
REQ-015 SHALL drive rf_we/rf_waddr/rf_wdata combinationally from the granted requester (zero-cycle latency); rf_we=0 with no grant.
REQ-016 SHALL assert lu_ready in the same cycle the LU write is granted; handshake completes when lu_valid and lu_ready are both 1.
REQ-017 SHALL transition IDLE->LU_WAIT when lu_valid=1 and LU is refused; LU_WAIT->IDLE on LU handshake.
REQ-018 SHALL count consecutive refused cycles in a 4-bit counter, cleared on LU handshake or lu_valid=0.
REQ-019 SHALL transition LU_WAIT->LU_FORCE when the counter reaches STARVE_MAX.
REQ-020 In LU_FORCE SHALL grant LU unconditionally and assert wb_stall iff wb_we=1; return to IDLE the next cycle.
REQ-021 SHALL keep wb_stall=0 in IDLE and LU_WAIT.
REQ-022 SHALL return to IDLE and clear the counter if lu_valid drops in LU_WAIT or LU_FORCE (a withdrawn request is not an error).
REQ-023 SHALL suppress writes to address 0 (rf_we=0) while still completing the requester's handshake.
REQ-024 Scoreboard: sb_set with nonzero sb_set_addr SHALL set that bit at the next edge; LU handshake SHALL clear bit lu_waddr.
REQ-025 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-026 hazard SHALL be combinational: OR of sb_busy at chk_addr1..3; address 0 never hazards.
REQ-027 Set of an already-set bit SHALL leave it set (issue is required to gate on hazard; not checked here).

Reset
REQ-028 On resetn=0 SHALL force state IDLE, counter 0, sb_busy 0, immediately and independent of clk.
REQ-029 During reset SHALL hold rf_we=0, lu_ready=0, wb_stall=0, hazard=0; in-flight LU request is discarded.

Configuration
REQ-030 Macro RF_ARB_SCOREBOARD_EN defined: scoreboard per REQ-024..027 compiled in.
REQ-031 Macro undefined: no scoreboard flops; sb_busy=0, hazard=0 constant; sb_set and chk_* ignored; arbitration unchanged.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, register-address width (5), data width (32), and the counter width.
REQ-033 Scoreboard SHALL be one sub-module rf_scoreboard (set/clear/check); arbitration FSM stays in rf_wport_arb.

Verification
REQ-034 WB only: wb_we=1, waddr=5, data=0x1234 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_stall=0.
REQ-035 Contention: wb_we=1 every cycle, lu_valid=1 waddr=7, STARVE_MAX=4 -> lu_ready=0 four cycles, fifth cycle rf_waddr=7, lu_ready=1, wb_stall=1, then IDLE.
REQ-036 x0: lu_valid=1 lu_waddr=0 alone -> lu_ready=1, rf_we=0.
REQ-037 Scoreboard: sb_set addr 9; next cycle chk_addr2=9 -> hazard=1, sb_busy[9]=1; LU handshake addr 9 -> next cycle hazard=0.
REQ-038 Same-cycle set and clear of addr 3 -> sb_busy[3]=1 after edge.
REQ-039 resetn low mid LU_WAIT with sb_busy=0x0000_0200 -> immediately counter 0, sb_busy=0, lu_ready=0, state IDLE.
